// File: rtl/decoder_pkg.sv
// Shared definitions for the registered address decoder: mode encodings and
// the decoded output width helper.
package decoder_pkg;

   localparam logic MODE_ONEHOT = 1'b0;
   localparam logic MODE_THERM  = 1'b1;

   function automatic int out_width(input int w);
      return 1 << w;
   endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational N-to-2^N decoder: one-hot or thermometer output, with enable
// gating and optional masking of address 0.
module decoder_core
   import decoder_pkg::*;
#(
   parameter int W         = 3,
   parameter int ZERO_MASK = 0
) (
   input  logic                    e,
   input  logic                    mode,
   input  logic [W-1:0]            a,
   output logic [out_width(W)-1:0] f
);

   localparam int N = out_width(W);

   logic masked;

   assign masked = (ZERO_MASK != 0) && (a == '0);

   always_comb begin
      f = '0;
      if (e && !masked) begin
         for (int i = 0; i < N; i++) begin
            if (mode == MODE_THERM) f[i] = (i <= int'(a));
            else                    f[i] = (i == int'(a));
         end
      end
   end

endmodule

// File: rtl/decoder_pipe.sv
// Registered decoder with valid/ready on both sides and a two-entry skid
// buffer (output register + skid register) for full-rate backpressure.
module decoder_pipe
   import decoder_pkg::*;
#(
   parameter int W         = 3,
   parameter int ZERO_MASK = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_e,
   input  logic                    in_mode,
   input  logic [W-1:0]            in_a,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [out_width(W)-1:0] out_f
);

   localparam int N = out_width(W);

   logic [N-1:0] dec_p0;
   logic [N-1:0] out_f_p1;
   logic [N-1:0] skid_f_p1;
   logic         vld_p1;
   logic         skid_vld_p1;
   logic         rdy_q;

   logic accept;
   logic consume;
   logic vld_n;
   logic skid_vld_n;
   logic load_out;
   logic load_skid;
   logic out_from_skid;

   // Stage p0: decode on the input side
   decoder_core #(
      .W         (W),
      .ZERO_MASK (ZERO_MASK)
   ) u_core (
      .e    (in_e),
      .mode (in_mode),
      .a    (in_a),
      .f    (dec_p0)
   );

   assign accept  = in_valid && rdy_q;
   assign consume = vld_p1 && out_ready;

   // rdy_q is low whenever the skid is full, so no input arrives while draining it
   always_comb begin
      vld_n         = vld_p1;
      skid_vld_n    = skid_vld_p1;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
      if (skid_vld_p1) begin
         if (consume) begin
            out_from_skid = 1'b1;
            skid_vld_n    = 1'b0;
         end
      end else if (accept) begin
         if (!vld_p1 || consume) begin
            load_out = 1'b1;
            vld_n    = 1'b1;
         end else begin
            load_skid  = 1'b1;
            skid_vld_n = 1'b1;
         end
      end else if (consume) begin
         vld_n = 1'b0;
      end
   end

   // Stage p1: output register and skid register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         rdy_q       <= 1'b0;
         out_f_p1    <= '0;
      end else begin
         vld_p1      <= vld_n;
         skid_vld_p1 <= skid_vld_n;
         rdy_q       <= !skid_vld_n;
         if (out_from_skid)  out_f_p1 <= skid_f_p1;
         else if (load_out)  out_f_p1 <= dec_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (load_skid) skid_f_p1 <= dec_p0;
   end

   assign in_ready  = rdy_q;
   assign out_valid = vld_p1;
   assign out_f     = out_f_p1;

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: three builds (W=3, W=3 masked, W=5) driven in
// lockstep and compared against a queue-based transaction model.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_e = 1'b0;
  logic        in_mode = 1'b0;
  logic [4:0]  in_a = '0;
  logic        out_ready = 1'b0;

  logic        rdy3, rdy3z, rdy5;
  logic        ov3, ov3z, ov5;
  logic [7:0]  f3, f3z;
  logic [31:0] f5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder_pipe #(.W(3), .ZERO_MASK(0)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3),
    .in_e(in_e), .in_mode(in_mode), .in_a(in_a[2:0]),
    .out_valid(ov3), .out_ready(out_ready), .out_f(f3));

  decoder_pipe #(.W(3), .ZERO_MASK(1)) dut3z (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3z),
    .in_e(in_e), .in_mode(in_mode), .in_a(in_a[2:0]),
    .out_valid(ov3z), .out_ready(out_ready), .out_f(f3z));

  decoder_pipe #(.W(5), .ZERO_MASK(0)) dut5 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy5),
    .in_e(in_e), .in_mode(in_mode), .in_a(in_a),
    .out_valid(ov5), .out_ready(out_ready), .out_f(f5));

  // Reference model: FIFO of accepted transactions {e, mode, a}, capacity 2
  logic [6:0] q[$];
  bit         m_rdy_en = 1'b0;

  function automatic bit m_rdy();
    return m_rdy_en && (q.size() < 2);
  endfunction

  function automatic bit m_vld();
    return q.size() > 0;
  endfunction

  function automatic logic [31:0] exp_f(input logic [6:0] t, input int w, input bit zm);
    int a;
    a = (w == 3) ? int'(t[2:0]) : int'(t[4:0]);
    if (!t[6] || (zm && a == 0)) return 32'd0;
    if (t[5]) return 32'((64'd1 << (a + 1)) - 64'd1);
    return 32'(64'd1 << a);
  endfunction

  always @(posedge clk or posedge reset) begin
    bit acc, con;
    if (reset) begin
      q.delete();
      m_rdy_en = 1'b0;
    end else begin
      acc = in_valid && m_rdy();
      con = out_ready && m_vld();
      if (con) void'(q.pop_front());
      if (acc) q.push_back({in_e, in_mode, in_a});
      m_rdy_en = 1'b1;
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ov3, ov3z, ov5} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 000", {ov3, ov3z, ov5});
    end
    checks++;
    if (f3 !== 8'h00 || f3z !== 8'h00 || f5 !== 32'h0) begin
      errors++;
      $display("FAIL reset_f: got %h %h %h expected 0", f3, f3z, f5);
    end
    checks++;
    if ({rdy3, rdy3z, rdy5} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 000", {rdy3, rdy3z, rdy5});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (rdy3 !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b expected 0", rdy3);
    end
    @(negedge clk);
    checks++;
    if ({rdy3, rdy3z, rdy5} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_release: got %b expected 111", {rdy3, rdy3z, rdy5});
    end
  endtask

  task automatic test_onehot();
    logic [7:0] one;
    one = 8'h01;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_e      = 1'b1;
    in_mode   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_a = 5'(i);
      cycle();
      checks++;
      if (ov3 !== 1'b1 || f3 !== (one << i)) begin
        errors++;
        $display("FAIL onehot_a%0d: got v=%b f=%h expected v=1 f=%h", i, ov3, f3, one << i);
      end
    end
    in_e = 1'b0;
    in_a = 5'd5;
    cycle();
    checks++;
    if (ov3 !== 1'b1 || f3 !== 8'h00 || f5 !== 32'h0) begin
      errors++;
      $display("FAIL disabled: got %h %h expected 00", f3, f5);
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (ov3 !== 1'b0) begin
      errors++;
      $display("FAIL onehot_idle_valid: got %b expected 0", ov3);
    end
    drain();
  endtask

  task automatic test_therm_mask();
    logic       md[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] ad[5] = '{5'd0, 5'd3, 5'd7, 5'd0, 5'd1};
    logic [7:0] e3[5] = '{8'h01, 8'h0F, 8'hFF, 8'h01, 8'h02};
    logic [7:0] ez[5] = '{8'h00, 8'h0F, 8'hFF, 8'h00, 8'h02};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_e      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_mode = md[i];
      in_a    = ad[i];
      cycle();
      checks++;
      if (f3 !== e3[i] || f3z !== ez[i]) begin
        errors++;
        $display("FAIL therm_mask_%0d: got %h/%h expected %h/%h", i, f3, f3z, e3[i], ez[i]);
      end
    end
    in_mode = 1'b0;
    in_a    = 5'd31;
    cycle();
    checks++;
    if (f5 !== 32'h8000_0000 || f3 !== 8'h80) begin
      errors++;
      $display("FAIL w5_onehot31: got %h/%h expected 80000000/80", f5, f3);
    end
    in_mode = 1'b1;
    in_a    = 5'd15;
    cycle();
    checks++;
    if (f5 !== 32'h0000_FFFF || f3 !== 8'hFF) begin
      errors++;
      $display("FAIL w5_therm15: got %h/%h expected 0000ffff/ff", f5, f3);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_o[3] = '{8'h02, 8'h04, 8'h08};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_e      = 1'b1;
    in_mode   = 1'b0;
    in_a      = 5'd1;
    cycle();
    checks++;
    if (ov3 !== 1'b1 || f3 !== 8'h02 || rdy3 !== 1'b1) begin
      errors++;
      $display("FAIL bp_first: got v=%b f=%h r=%b expected v=1 f=02 r=1", ov3, f3, rdy3);
    end
    in_a = 5'd2;
    cycle();
    in_a = 5'd3;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ov3 !== 1'b1 || f3 !== 8'h02 || rdy3 !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_%0d: got v=%b f=%h r=%b expected v=1 f=02 r=0", i, ov3, f3, rdy3);
      end
      if (i == 0) cycle();
    end
    cycle();
    checks++;
    if (f3 !== 8'h02 || rdy3 !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall_2: got f=%h r=%b expected f=02 r=0", f3, rdy3);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov3 !== 1'b1 || f3 !== exp_o[i]) begin
        errors++;
        $display("FAIL bp_order_%0d: got v=%b f=%h expected v=1 f=%h", i, ov3, f3, exp_o[i]);
      end
      cycle();
      if (i == 1) in_valid = 1'b0;
    end
    checks++;
    if (ov3 !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: got %b expected 0", ov3);
    end
    drain();
  endtask

  task automatic test_random(input int n, input int rdy_pct);
    logic [31:0] e3, e3z, e5;
    logic [7:0]  pf3;
    logic [31:0] pf5;
    bit          pstall;
    for (int c = 0; c < n; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_e      = ($urandom_range(0, 7) != 0);
      in_mode   = 1'($urandom_range(0, 1));
      in_a      = 5'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      pstall    = ov3 && !out_ready;
      pf3       = f3;
      pf5       = f5;
      cycle();
      checks++;
      if ({rdy3, rdy3z, rdy5} !== {3{m_rdy()}}) begin
        errors++;
        $display("FAIL rnd_ready c%0d: got %b expected %b", c, {rdy3, rdy3z, rdy5}, m_rdy());
      end
      checks++;
      if ({ov3, ov3z, ov5} !== {3{m_vld()}}) begin
        errors++;
        $display("FAIL rnd_valid c%0d: got %b expected %b", c, {ov3, ov3z, ov5}, m_vld());
      end
      if (q.size() > 0) begin
        e3  = exp_f(q[0], 3, 1'b0);
        e3z = exp_f(q[0], 3, 1'b1);
        e5  = exp_f(q[0], 5, 1'b0);
        checks++;
        if (f3 !== e3[7:0] || f3z !== e3z[7:0] || f5 !== e5) begin
          errors++;
          $display("FAIL rnd_data c%0d: got %h %h %h expected %h %h %h",
                   c, f3, f3z, f5, e3[7:0], e3z[7:0], e5);
        end
      end
      if (pstall) begin
        checks++;
        if (ov3 !== 1'b1 || f3 !== pf3 || f5 !== pf5) begin
          errors++;
          $display("FAIL rnd_stall c%0d: got %h %h expected %h %h", c, f3, f5, pf3, pf5);
        end
      end
      if (rdy_pct == 100) begin
        checks++;
        if (rdy3 !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready c%0d: got %b expected 1", c, rdy3);
        end
      end
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_e      = 1'b1;
    in_mode   = 1'b0;
    in_a      = 5'd2;
    cycle();
    in_a = 5'd4;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (ov3 !== 1'b1 || rdy3 !== 1'b0) begin
      errors++;
      $display("FAIL mid_inflight: got v=%b r=%b expected v=1 r=0", ov3, rdy3);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ov3, ov3z, ov5} !== 3'b000 || f3 !== 8'h00 || f3z !== 8'h00 || f5 !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_async: got v=%b f=%h %h %h expected 000 and 0",
               {ov3, ov3z, ov5}, f3, f3z, f5);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({rdy3, rdy3z, rdy5} !== 3'b111 || ov3 !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: got r=%b v=%b expected r=111 v=0", {rdy3, rdy3z, rdy5}, ov3);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_therm_mask();
    test_backpressure();
    test_random(200, 100);
    test_random(400, 60);
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
